// File: rtl/wire_arb_pkg.sv
// Shared types and defaults for the single-wire round-robin arbiter.
package wire_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Never returns zero, so an index or counter of two values still gets one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_wire_arbiter_rr_pick.sv
// Rotating-priority selector: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import wire_arb_pkg::*;
#(
  parameter  int N = N_REQ_DEF,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  int j;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_wire_arbiter.sv
// Round-robin owner of one shared 1-bit wire, with a hold limit under contention.
module shared_wire_arbiter
  import wire_arb_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int IW       = idx_width(N_REQ),
  localparam int HW       = idx_width(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    gnt_id,
  output logic             out
);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic             owner_req, others_pending, forced_rel, release_own;
  logic [IW-1:0]    next_ptr, pick_ptr, pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;

  // On release the pointer moves past the owner first, so it ranks last.
  always_comb begin
    owner_req      = req[gnt_id_q];
    others_pending = |(req & ~grant_q);
    forced_rel     = (hold_q == HOLD_LAST) && others_pending;
    release_own    = (state_q == ST_OWNED) && (!owner_req || forced_rel);
    next_ptr       = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;
    pick_ptr       = release_own ? next_ptr : ptr_q;
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    gnt_id_d      = gnt_id_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d       = ST_OWNED;
          grant_d       = pick_onehot;
          grant_valid_d = 1'b1;
          gnt_id_d      = pick_idx;
          hold_d        = '0;
        end
      end
      ST_OWNED: begin
        if (release_own) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (pick_found) begin
            grant_d  = pick_onehot;
            gnt_id_d = pick_idx;
          end else begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            gnt_id_d      = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        gnt_id_d      = '0;
        hold_d        = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      gnt_id_q      <= '0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      gnt_id_q      <= gnt_id_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign gnt_id      = gnt_id_q;
  assign out         = grant_valid_q & din[gnt_id_q];

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_valid_match:   assert property (@(posedge clk) disable iff (!rst_n) grant_valid_q == (|grant_q));
  a_id_match:      assert property (@(posedge clk) disable iff (!rst_n) grant_valid_q |-> grant_q[gnt_id_q]);

endmodule

// File: tb/tb_shared_wire_arbiter.sv
// Directed bench for shared_wire_arbiter (N_REQ=4, MAX_HOLD=8) with immediate-assertion checks.
module tb_shared_wire_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] gnt_id;
  logic       out;

  int total = 0;
  int bad   = 0;

  shared_wire_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .din         (din),
    .grant       (grant),
    .grant_valid (grant_valid),
    .gnt_id      (gnt_id),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs and checks all happen a couple of ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic o);
    checkVal($sformatf("%s.grant", tag), 32'(grant), 32'(g));
    checkVal($sformatf("%s.valid", tag), 32'(grant_valid), 32'(v));
    checkVal($sformatf("%s.gnt_id", tag), 32'(gnt_id), 32'(id));
    checkVal($sformatf("%s.out", tag), 32'(out), 32'(o));
  endtask

  task automatic checkIdle(input string tag);
    checkVal($sformatf("%s.grant", tag), 32'(grant), 32'h0);
    checkVal($sformatf("%s.valid", tag), 32'(grant_valid), 32'h0);
    checkVal($sformatf("%s.out", tag), 32'(out), 32'h0);
  endtask

  initial begin
    logic [3:0] d;

    // Reset held with every requester active.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b1111);
    tick();
    tick();
    checkOutput("reset", 4'b0000, 1'b0, 2'd0, 1'b0);

    // First edge after reset release arbitrates from ptr=0.
    rst_n = 1'b1;
    tick();
    checkOutput("first_grant", 4'b0001, 1'b1, 2'd0, 1'b1);
    applyStimulus(4'b0000, 4'b1111);
    tick();
    checkIdle("drop_to_idle");

    // Sole requester 2 keeps the grant; out follows din[2] with no delay.
    applyStimulus(4'b0100, 4'b0000);
    tick();
    for (int i = 0; i < 20; i++) begin
      d    = (i % 2 == 1) ? 4'b0100 : 4'b1011;
      applyStimulus(4'b0100, d);
      checkVal($sformatf("solo%0d.grant", i), 32'(grant), 32'h4);
      checkVal($sformatf("solo%0d.out", i), 32'(out), 32'(d[2]));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkIdle("solo_end");

    // Restart from ptr=0 for the round-robin sequence.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;

    applyStimulus(4'b1011, 4'b1010);
    tick();
    checkOutput("rr0_c1", 4'b0001, 1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("rr0_c2", 4'b0001, 1'b1, 2'd0, 1'b0);
    applyStimulus(4'b1010, 4'b1010);
    tick();
    checkOutput("rr1_c1", 4'b0010, 1'b1, 2'd1, 1'b1);
    applyStimulus(4'b1011, 4'b1010);
    tick();
    checkOutput("rr1_c2", 4'b0010, 1'b1, 2'd1, 1'b1);
    applyStimulus(4'b1001, 4'b1010);
    tick();
    checkOutput("rr3_c1", 4'b1000, 1'b1, 2'd3, 1'b1);
    applyStimulus(4'b1011, 4'b1010);
    tick();
    checkOutput("rr3_c2", 4'b1000, 1'b1, 2'd3, 1'b1);
    applyStimulus(4'b0011, 4'b1010);
    tick();
    checkOutput("rr0_again", 4'b0001, 1'b1, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b1010);
    tick();
    checkIdle("rr_end");

    // Continuous contention between 0 and 1, starting with ptr=1.
    applyStimulus(4'b0011, 4'b0001);
    tick();
    checkOutput("hold_a0", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput($sformatf("hold_a%0d", k), 4'b0010, 1'b1, 2'd1, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("hold_b%0d", k), 4'b0001, 1'b1, 2'd0, 1'b1);
    end
    tick();
    checkOutput("hold_c0", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Owner 1 drops as 0 and 2 rise; new ptr=2 selects requester 2.
    applyStimulus(4'b0010, 4'b0100);
    tick();
    checkOutput("sim_pre", 4'b0010, 1'b1, 2'd1, 1'b0);
    applyStimulus(4'b0101, 4'b0100);
    tick();
    checkOutput("sim_handoff", 4'b0100, 1'b1, 2'd2, 1'b1);

    // Hand off to owner 3, then reset asynchronously between edges.
    applyStimulus(4'b1000, 4'b1000);
    tick();
    checkOutput("owner3", 4'b1000, 1'b1, 2'd3, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0001);
    tick();
    checkOutput("after_reset", 4'b0001, 1'b1, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_wire_arbiter.md
# shared_wire_arbiter

Round-robin arbiter that shares one 1-bit output wire between `N_REQ` requesters. Each requester raises `req` and presents its bit on `din`. The arbiter grants one owner at a time, forwards that owner's bit combinationally to `out`, and bounds ownership under contention with a hold limit. It sits in front of any single-wire sink in the design, such as an output pin or a 1-bit bus.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters; must be ≥2.
- `MAX_HOLD`, 8, maximum consecutive grant cycles while another requester waits; must be ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  `N_REQ`  request vector, one bit per requester.
- `din`  in  `N_REQ`  data bit of each requester.
- `grant`  out  `N_REQ`  one-hot grant, registered.
- `grant_valid`  out  1  high when any grant is held, registered.
- `gnt_id`  out  `$clog2(N_REQ)`  index of the current owner, registered.
- `out`  out  1  shared wire: equals `din[gnt_id]` when `grant_valid` is high, otherwise 0.

## Operation
- FSM has two states:
  - IDLE: no owner.
  - OWNED: `grant` holds exactly one bit.
- Round-robin pointer `ptr` marks the highest-priority index. Priority runs `ptr`, `ptr+1`, … modulo `N_REQ`.
- IDLE → OWNED: at an edge with `req != 0`, grant the first requesting index at or after `ptr`.
- OWNED → OWNED (same owner): `req[owner]` is still high and the forced-release condition does not apply. The hold counter increments and saturates at `MAX_HOLD-1`.
- Forced release: hold counter equals `MAX_HOLD-1` and another requester is pending.
- Release: `req[owner]` is low, or forced release applies. At that same edge:
  - `ptr` becomes `owner+1` modulo `N_REQ`.
  - Re-arbitrate using the new `ptr`. The former owner has lowest priority; it is excluded if its `req` is low.
  - If there is a winner, go to OWNED with the new owner and hold counter 0. This is a zero-bubble handoff.
  - Otherwise go to IDLE.
- Without contention the hold counter never forces release; a sole requester keeps the grant indefinitely.
- `out` is combinational from `din` through the grant mux. It has no register stage and no dependence on `req` within the cycle.
- `din` of non-owners is ignored.

## Timing
- Reset values: state IDLE, `grant`=0, `grant_valid`=0, `gnt_id`=0, `ptr`=0, hold counter 0, and therefore `out`=0.
- Reset is asynchronous. Asserting `rst_n` low in any state clears all registers immediately, including a mid-grant owner. The first arbitration happens at the first rising edge after `rst_n` rises.
- Request-to-grant latency: `req` high before edge k gives a grant visible after edge k, i.e. 1 cycle.
- Owner drop to release latency: `req[owner]` low before edge k gives the grant removed or handed off after edge k.
- Data latency is 0 cycles from `din[owner]` to `out`.
- Under continuous contention, the maximum grant length is `MAX_HOLD` cycles.
- Simultaneous new requests and release in the same cycle: the new requests participate in that edge's arbitration.
- Owner dropping `req` and a forced release in the same cycle are treated as a single release with identical `ptr` update.
- `req` of a non-owner dropping while it waits: that requester is simply not selected.
- Invariants checked by assertion:
  - `grant` is zero or one-hot.
  - `grant_valid == |grant`.
  - `grant[gnt_id]` is set whenever `grant_valid` is high.

## Structure
- Package `wire_arb_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_OWNED`).
  - Default constants `N_REQ_DEF`=4 and `MAX_HOLD_DEF`=8.
  - Index-width function.
- Sub-module `rr_pick`: combinational rotate-priority selector. Inputs: request vector and `ptr`. Outputs: found flag, winner index, one-hot winner. Reused by IDLE entry and by release.
- Top level holds the FSM, `ptr`, hold counter, grant registers and the output mux.

## Test plan
- Reset and idle: `rst_n`=0 with `req`=4'b1111 and `din`=4'b1111 → `grant`=0, `grant_valid`=0, `out`=0. After release of reset, first edge gives `grant`=4'b0001 and `gnt_id`=0.
- Single requester passthrough: `req`=4'b0100 alone, `din[2]` toggled 0,1,0,1 for 20 cycles → `grant`=4'b0100 held throughout, no forced release, `out` follows `din[2]` with 0 delay.
- Round-robin handoff: `req`=4'b1011 held; each owner drops `req` for one cycle after 2 cycles of ownership → owners are 0,1,3,0,… with no idle cycle between grants.
- Hold limit: `req`=4'b0011 held constant with `MAX_HOLD`=8 → owner 0 for exactly 8 cycles, then owner 1 for 8, alternating; `grant_valid` never drops.
- Simultaneous release and new request: owner 1 drops `req` on the same edge that `req[2]` and `req[0]` rise with `ptr`=2 → `grant`=4'b0100 on the next cycle.
- Reset mid-grant: `rst_n` pulsed low asynchronously between edges while owner 3 is granted → `grant`, `gnt_id`, `out` are 0 immediately. After reset, arbitration restarts from `ptr`=0.
